// File: rtl/mux_n_sync_pkg.sv
// mux_n_pkg: shared types and width helpers for the mux_n_sync slice.
// Optional feature macro used elsewhere in this slice: MUXN_ERR_EN.
package mux_n_pkg;

  // Two-state control: free-running selection or blanked settle window.
  typedef enum logic {
    RUN    = 1'b0,
    SETTLE = 1'b1
  } state_e;

  // Ceiling log2 for elaboration-time width arithmetic (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Select width: enough bits to index every channel, never less than one.
  function automatic int sel_width(input int ch);
    int w;
    w = clog2(ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_n_sync_if.sv
// mux_n_sync_if: bundles the channel inputs, select handshake and status outputs.
// The sel_err signal exists only when MUXN_ERR_EN is defined.
interface mux_n_sync_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  import mux_n_pkg::*;

  localparam int SW = sel_width(CH);

  logic [CH*WIDTH-1:0] in_data;
  logic [SW-1:0]       sel;
  logic                sel_req;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                busy;
  logic [SW-1:0]       sel_cur;
`ifdef MUXN_ERR_EN
  logic                sel_err;
`endif

  // Source side: drives channels and select requests, observes status.
  modport master (
    output in_data, sel, sel_req,
    input  out_data, out_valid, busy, sel_cur
`ifdef MUXN_ERR_EN
    , input sel_err
`endif
  );

  // Multiplexer side: consumes channels and requests, drives status.
  modport slave (
    input  in_data, sel, sel_req,
    output out_data, out_valid, busy, sel_cur
`ifdef MUXN_ERR_EN
    , output sel_err
`endif
  );

endinterface

// File: rtl/mux_n_sync_core.sv
// mux_n_core: purely combinational CH:1 selector of WIDTH-bit channels.
module mux_n_core
  import mux_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SW    = sel_width(CH)
) (
  input  logic [CH*WIDTH-1:0] in_data_i,
  input  logic [SW-1:0]       sel_i,
  output logic [WIDTH-1:0]    data_o
);

  // Pick the channel addressed by sel_i; out-of-range indices give zero.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < CH; k++) begin
      if (sel_i == SW'(k)) begin
        data_o = in_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_sync.sv
// mux_n_sync: registered N-channel multiplexer with a blanked, handshaked
// select change. Define MUXN_ERR_EN to get the sel_err rejection pulse.
module mux_n_sync #(
  parameter int WIDTH  = 8,
  parameter int CH     = 4,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_n_sync_if.slave  bus
);
  import mux_n_pkg::*;

  localparam int             SW     = sel_width(CH);
  localparam int             CW     = clog2(SETTLE + 1);
  localparam logic [SW:0]    CH_L   = (SW + 1)'(CH);
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    selPend_q, selPend_d;
  logic [SW-1:0]    selCur_q, selCur_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] coreData;
  logic             reqValid;
  logic             busy;

  // A request is only honoured when it names an existing channel.
  assign reqValid = bus.sel_req && ({1'b0, bus.sel} < CH_L);

  mux_n_core #(
    .WIDTH (WIDTH),
    .CH    (CH)
  ) uCore (
    .in_data_i (bus.in_data),
    .sel_i     (selCur_q),
    .data_o    (coreData)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state plus settle counter and channel bookkeeping; a valid request
  // during settling restarts the window even if it names the current channel.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    selPend_d = selPend_q;
    selCur_d  = selCur_q;
    case (state_q)
      RUN: begin
        if (reqValid && (bus.sel != selCur_q)) begin
          selPend_d = bus.sel;
          cnt_d     = RELOAD;
          state_d   = mux_n_pkg::SETTLE;
        end
      end
      mux_n_pkg::SETTLE: begin
        if (reqValid) begin
          selPend_d = bus.sel;
          cnt_d     = RELOAD;
        end else if (cnt_q == '0) begin
          selCur_d = selPend_q;
          state_d  = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs: data only follows the channel while staying in RUN; anything
  // else freezes it and drops valid.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = 1'b0;
    busy       = (state_q == mux_n_pkg::SETTLE);
    if ((state_q == RUN) && (state_d == RUN)) begin
      outData_d  = coreData;
      outValid_d = 1'b1;
    end
  end

  // Datapath and bookkeeping registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      selPend_q  <= '0;
      selCur_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      selPend_q  <= selPend_d;
      selCur_q   <= selCur_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy;
  assign bus.sel_cur   = selCur_q;

`ifdef MUXN_ERR_EN
  logic selErr_q;

  // One-cycle pulse in the cycle after an out-of-range request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) selErr_q <= 1'b0;
    else        selErr_q <= bus.sel_req && !({1'b0, bus.sel} < CH_L);
  end

  assign bus.sel_err = selErr_q;
`endif

endmodule

// File: tb/tb_mux_n_sync.sv
// tb_mux_n_sync: drives a 4-channel and a 3-channel mux_n_sync side by side.
// sel_err checks are compiled in only when MUXN_ERR_EN is defined.
module tb_mux_n_sync;

  localparam int SETTLE_C = 2;

  logic clk;
  logic rst_n;

  mux_n_sync_if #(.WIDTH(8), .CH(4)) bus4 ();
  mux_n_sync_if #(.WIDTH(8), .CH(3)) bus3 ();

  mux_n_sync #(.WIDTH(8), .CH(4), .SETTLE(SETTLE_C)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_n_sync #(.WIDTH(8), .CH(3), .SETTLE(SETTLE_C)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the active channel changes SETTLE edges after the most
  // recent accepted request; output is valid only on edges spent wholly in run.
  int          cycleN;
  int          mCur;
  int          mPend;
  int          mReqCycle;
  bit          mPending;
  logic [7:0]  expData;
  logic        expValid;
  logic        expBusy;

  logic        req3;
  logic [1:0]  sel3;
  logic [23:0] data3;

  localparam logic [31:0] CHANS = 32'h44332211;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mCur      = 0;
    mPend     = 0;
    mReqCycle = 0;
    mPending  = 1'b0;
    expData   = 8'h00;
    expValid  = 1'b0;
    expBusy   = 1'b0;
  endtask

  task automatic tick(input logic req, input logic [1:0] s, input logic [31:0] d);
    bit pendBefore;
    bit valid;
    bus4.sel_req = req;
    bus4.sel     = s;
    bus4.in_data = d;
    bus3.sel_req = req3;
    bus3.sel     = sel3;
    bus3.in_data = data3;
    @(posedge clk);
    cycleN++;
    valid      = req && (int'(s) < 4);
    pendBefore = mPending;
    if (mPending) begin
      if (valid) begin
        mPend     = int'(s);
        mReqCycle = cycleN;
      end else if (cycleN == mReqCycle + SETTLE_C) begin
        mCur     = mPend;
        mPending = 1'b0;
      end
    end else if (valid && int'(s) != mCur) begin
      mPend     = int'(s);
      mReqCycle = cycleN;
      mPending  = 1'b1;
    end
    expValid = !pendBefore && !mPending;
    expBusy  = mPending;
    if (expValid) expData = d[mCur*8 +: 8];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus4.out_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_data: got %h need 00", bus4.out_data); end
    checks++;
    if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b need 0", bus4.out_valid); end
    checks++;
    if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b need 0", bus4.busy); end
    checks++;
    if (bus4.sel_cur !== 2'd0) begin failures++; $display("[TB] FAIL rst_selcur: got %0d need 0", bus4.sel_cur); end
`ifdef MUXN_ERR_EN
    checks++;
    if (bus4.sel_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b need 0", bus4.sel_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 2'd0, CHANS);
    checks++;
    if (bus4.out_data !== 8'h11) begin failures++; $display("[TB] FAIL first_data: got %h need 11", bus4.out_data); end
    checks++;
    if (bus4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_valid: got %b need 1", bus4.out_valid); end
    checks++;
    if (bus4.sel_cur !== 2'd0) begin failures++; $display("[TB] FAIL first_selcur: got %0d need 0", bus4.sel_cur); end
  endtask

  task automatic test_switch();
    tick(1'b1, 2'd2, CHANS);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL sw_blank%0d: got %b need 0", i, bus4.out_valid); end
      checks++;
      if (bus4.out_data !== 8'h11) begin failures++; $display("[TB] FAIL sw_hold%0d: got %h need 11", i, bus4.out_data); end
      checks++;
      if (bus4.busy !== expBusy) begin failures++; $display("[TB] FAIL sw_busy%0d: got %b need %b", i, bus4.busy, expBusy); end
      tick(1'b0, 2'd0, CHANS);
    end
    checks++;
    if (bus4.out_data !== 8'h33) begin failures++; $display("[TB] FAIL sw_data: got %h need 33", bus4.out_data); end
    checks++;
    if (bus4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL sw_valid: got %b need 1", bus4.out_valid); end
    checks++;
    if (bus4.sel_cur !== 2'd2) begin failures++; $display("[TB] FAIL sw_selcur: got %0d need 2", bus4.sel_cur); end
  endtask

  task automatic test_restart();
    tick(1'b1, 2'd1, CHANS);
    tick(1'b1, 2'd3, CHANS);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'd0, CHANS);
      checks++;
      if (bus4.out_valid !== expValid) begin failures++; $display("[TB] FAIL rs_valid%0d: got %b need %b", i, bus4.out_valid, expValid); end
      checks++;
      if (bus4.sel_cur !== 2'(mCur)) begin failures++; $display("[TB] FAIL rs_selcur%0d: got %0d need %0d", i, bus4.sel_cur, mCur); end
    end
    checks++;
    if (bus4.out_data !== 8'h44) begin failures++; $display("[TB] FAIL rs_data: got %h need 44", bus4.out_data); end
    checks++;
    if (bus4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rs_final_valid: got %b need 1", bus4.out_valid); end
  endtask

  task automatic test_same_sel();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'd3, CHANS);
      checks++;
      if (bus4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL same_valid%0d: got %b need 1", i, bus4.out_valid); end
      checks++;
      if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL same_busy%0d: got %b need 0", i, bus4.busy); end
    end
  endtask

  task automatic test_out_of_range();
    req3 = 1'b1;
    sel3 = 2'd3;
    tick(1'b0, 2'd0, CHANS);
    req3 = 1'b0;
`ifdef MUXN_ERR_EN
    checks++;
    if (bus3.sel_err !== 1'b1) begin failures++; $display("[TB] FAIL oor_err: got %b need 1", bus3.sel_err); end
`endif
    checks++;
    if (bus3.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL oor_valid: got %b need 1", bus3.out_valid); end
    checks++;
    if (bus3.sel_cur !== 2'd0) begin failures++; $display("[TB] FAIL oor_selcur: got %0d need 0", bus3.sel_cur); end
    checks++;
    if (bus3.busy !== 1'b0) begin failures++; $display("[TB] FAIL oor_busy: got %b need 0", bus3.busy); end
    tick(1'b0, 2'd0, CHANS);
`ifdef MUXN_ERR_EN
    checks++;
    if (bus3.sel_err !== 1'b0) begin failures++; $display("[TB] FAIL oor_err_drop: got %b need 0", bus3.sel_err); end
`endif
    checks++;
    if (bus3.out_data !== 8'hA1) begin failures++; $display("[TB] FAIL oor_data: got %h need a1", bus3.out_data); end
  endtask

  task automatic test_random();
    logic        r;
    logic [1:0]  s;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 3) == 0);
      s = 2'($urandom_range(0, 3));
      d = $urandom;
      tick(r, s, d);
      checks++;
      if (bus4.out_data !== expData) begin failures++; $display("[TB] FAIL rnd_data@%0d: got %h need %h", i, bus4.out_data, expData); end
      checks++;
      if (bus4.out_valid !== expValid) begin failures++; $display("[TB] FAIL rnd_valid@%0d: got %b need %b", i, bus4.out_valid, expValid); end
      checks++;
      if (bus4.busy !== expBusy) begin failures++; $display("[TB] FAIL rnd_busy@%0d: got %b need %b", i, bus4.busy, expBusy); end
      checks++;
      if (bus4.sel_cur !== 2'(mCur)) begin failures++; $display("[TB] FAIL rnd_selcur@%0d: got %0d need %0d", i, bus4.sel_cur, mCur); end
`ifdef MUXN_ERR_EN
      checks++;
      if (bus4.sel_err !== 1'b0) begin failures++; $display("[TB] FAIL rnd_err@%0d: got %b need 0", i, bus4.sel_err); end
`endif
    end
  endtask

  task automatic test_reset_mid_settle();
    tick(1'b0, 2'd0, CHANS);
    if (mPending) tick(1'b0, 2'd0, CHANS);
    if (mPending) tick(1'b0, 2'd0, CHANS);
    tick(1'b1, (mCur == 1) ? 2'd2 : 2'd1, CHANS);
    checks++;
    if (bus4.busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy: got %b need 1", bus4.busy); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus4.out_data !== 8'h00) begin failures++; $display("[TB] FAIL mid_data: got %h need 00", bus4.out_data); end
    checks++;
    if (bus4.busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy_clr: got %b need 0", bus4.busy); end
    checks++;
    if (bus4.sel_cur !== 2'd0) begin failures++; $display("[TB] FAIL mid_selcur: got %0d need 0", bus4.sel_cur); end
    checks++;
    if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid: got %b need 0", bus4.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'd0, CHANS);
      checks++;
      if (bus4.out_data !== 8'h11) begin failures++; $display("[TB] FAIL mid_after%0d: got %h need 11", i, bus4.out_data); end
      checks++;
      if (bus4.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_after_valid%0d: got %b need 1", i, bus4.out_valid); end
    end
  endtask

  initial begin
    cycleN       = 0;
    req3         = 1'b0;
    sel3         = 2'd0;
    data3        = 24'hC3B2A1;
    bus4.sel_req = 1'b0;
    bus4.sel     = 2'd0;
    bus4.in_data = CHANS;
    bus3.sel_req = 1'b0;
    bus3.sel     = 2'd0;
    bus3.in_data = data3;
    test_reset();
    test_switch();
    test_restart();
    test_same_sel();
    test_out_of_range();
    test_random();
    test_reset_mid_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
